// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard ball kinematics blocks.
// Positions are 17-bit unsigned fixed point: 11 integer pixel bits and
// POS_FRAC fraction bits. Velocities are 11-bit signed, in 1/64 pixel
// per frame, so one velocity LSB equals one position LSB.
package billiard_pkg;

    localparam int POS_FRAC  = 6;
    localparam int BALL_SIZE = 32;

    typedef logic signed [10:0] vel_t;
    typedef logic [16:0]        pos_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_WALL,
        ST_FRICT
    } state_e;

    // Two's complement negation that maps the most negative value to the
    // most positive one instead of wrapping back onto itself.
    function automatic vel_t neg_sat(input vel_t v);
        if (v == vel_t'({1'b1, 10'b0})) begin
            return vel_t'(11'sd1023);
        end
        return vel_t'(-v);
    endfunction

endpackage

// File: rtl/axis_integrator.sv
// One axis of the ball kinematics: holds the sub-pixel position and the
// velocity for that axis and applies the per-frame update steps when the
// controller strobes them.
//   clk, reset     : clock, synchronous active-high reset
//   move_i         : integrate velocity into position (negative clamps to 0)
//   wall_i         : clamp to [MIN, MAX] and reflect velocity if out of range
//   frict_i        : apply one friction decay step to the velocity
//   load_i         : overwrite velocity with load_vel_i (wins over the others)
//   pos_o          : integer pixel position
//   vel_o          : current velocity
//   refl_o         : current position is outside [MIN, MAX]
module axis_integrator
    import billiard_pkg::*;
#(
    parameter logic [10:0] INIT           = 11'd100,
    parameter logic [10:0] MIN            = 11'd32,
    parameter logic [10:0] MAX            = 11'd575,
    parameter int          FRICTION_SHIFT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_i,
    input  logic        wall_i,
    input  logic        frict_i,
    input  logic        load_i,
    input  vel_t        load_vel_i,
    output logic [10:0] pos_o,
    output vel_t        vel_o,
    output logic        refl_o
);

    pos_t        pos_q;
    vel_t        vel_q;
    logic [17:0] sum;
    pos_t        move_pos;
    pos_t        wall_pos;
    logic [10:0] int_pos;
    logic        below;
    logic        above;
    logic [10:0] mag;
    logic [10:0] dec;
    logic [10:0] new_mag;
    vel_t        frict_vel;

    always_comb begin
        // 18-bit sum so an underflow past zero shows up in the top bit.
        sum      = {1'b0, pos_q} + {{7{vel_q[10]}}, vel_q};
        move_pos = sum[17] ? '0 : sum[16:0];

        int_pos  = pos_q[16:POS_FRAC];
        below    = int_pos < MIN;
        above    = int_pos > MAX;
        refl_o   = below | above;
        wall_pos = pos_q;
        if (below) begin
            wall_pos = {MIN, {POS_FRAC{1'b0}}};
        end else if (above) begin
            wall_pos = {MAX, {POS_FRAC{1'b0}}};
        end

        // Magnitude fits 11 unsigned bits even for -1024.
        mag = vel_q[10] ? unsigned'(vel_t'(-vel_q)) : unsigned'(vel_q);
        dec = mag >> FRICTION_SHIFT;
        if (dec == '0) begin
            dec = 11'd1;
        end
        new_mag   = (mag > dec) ? (mag - dec) : '0;
        frict_vel = vel_q[10] ? vel_t'(-new_mag) : vel_t'(new_mag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= {INIT, {POS_FRAC{1'b0}}};
            vel_q <= '0;
        end else begin
            if (move_i) begin
                pos_q <= move_pos;
            end else if (wall_i) begin
                pos_q <= wall_pos;
            end

            if (load_i) begin
                vel_q <= load_vel_i;
            end else if (wall_i && refl_o) begin
                vel_q <= neg_sat(vel_q);
            end else if (frict_i) begin
                vel_q <= frict_vel;
            end
        end
    end

    assign pos_o = pos_q[16:POS_FRAC];
    assign vel_o = vel_q;

endmodule

// File: rtl/ball_mover.sv
// Per-ball kinematics engine. Once per frame it integrates velocity into
// position, reflects off the cushions and applies friction; velocity
// overrides from the cue strike and the collision block are accepted at
// any time and deferred while a frame update is in flight.
//   clk, reset                  : clock, synchronous active-high reset
//   startOfFrame                : one pulse per video frame
//   collisionOccurred           : load ballVelXIn/ballVelYIn
//   hitStrike                   : load hitVelX/hitVelY (wins over collision)
//   ballTopLeftPosX/Y           : integer pixel position
//   ballVelX/Y                  : current velocity, 1/64 pixel per frame
//   moving                      : either velocity component nonzero
//   wallHit                     : one-cycle pulse after a reflection
//
// Each state's work is committed on the clock edge that enters it, so the
// outputs seen while in a state already carry that state's result.
//   state    | meaning
//   ST_IDLE  | waiting for startOfFrame; overrides load velocity directly
//   ST_MOVE  | position holds pos + v (negative clamped to 0)
//   ST_WALL  | position clamped to cushions, velocity reflected
//   ST_FRICT | friction applied on period boundary; wallHit pulses here
module ball_mover
    import billiard_pkg::*;
#(
    parameter logic [10:0] INIT_X          = 11'd100,
    parameter logic [10:0] INIT_Y          = 11'd100,
    parameter logic [10:0] X_MIN           = 11'd32,
    parameter logic [10:0] X_MAX           = 11'd575,
    parameter logic [10:0] Y_MIN           = 11'd32,
    parameter logic [10:0] Y_MAX           = 11'd415,
    parameter int          FRICTION_SHIFT  = 5,
    parameter int          FRICTION_PERIOD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        collisionOccurred,
    input  vel_t        ballVelXIn,
    input  vel_t        ballVelYIn,
    input  logic        hitStrike,
    input  vel_t        hitVelX,
    input  vel_t        hitVelY,
    output logic [10:0] ballTopLeftPosX,
    output logic [10:0] ballTopLeftPosY,
    output vel_t        ballVelX,
    output vel_t        ballVelY,
    output logic        moving,
    output logic        wallHit
);

    state_e     state_q;
    logic [3:0] frame_cnt_q;
    logic       pend_valid_q;
    vel_t       pend_x_q;
    vel_t       pend_y_q;
    logic       wall_seen_q;
    logic       wall_hit_q;

    logic       ovr_req;
    vel_t       ovr_x;
    vel_t       ovr_y;
    logic       do_move;
    logic       do_wall;
    logic       do_frict;
    logic       do_load;
    vel_t       load_x;
    vel_t       load_y;
    logic       refl_x;
    logic       refl_y;

    always_comb begin
        ovr_req  = hitStrike | collisionOccurred;
        ovr_x    = hitStrike ? hitVelX : ballVelXIn;
        ovr_y    = hitStrike ? hitVelY : ballVelYIn;

        do_move  = (state_q == ST_IDLE) && startOfFrame;
        do_wall  = (state_q == ST_MOVE);
        do_frict = (state_q == ST_WALL) && (frame_cnt_q == 4'(FRICTION_PERIOD - 1));

        // On the FRICT->IDLE edge a request arriving in that same cycle is
        // newer than anything pending, so it goes straight in.
        do_load  = ((state_q == ST_IDLE) && ovr_req) ||
                   ((state_q == ST_FRICT) && (ovr_req || pend_valid_q));
        load_x   = ovr_req ? ovr_x : pend_x_q;
        load_y   = ovr_req ? ovr_y : pend_y_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            wall_seen_q  <= 1'b0;
            wall_hit_q   <= 1'b0;
        end else begin
            wall_hit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (startOfFrame) begin
                        state_q <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    state_q     <= ST_WALL;
                    wall_seen_q <= refl_x | refl_y;
                end
                ST_WALL: begin
                    state_q    <= ST_FRICT;
                    wall_hit_q <= wall_seen_q;
                    if (frame_cnt_q == 4'(FRICTION_PERIOD - 1)) begin
                        frame_cnt_q <= '0;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 4'd1;
                    end
                end
                ST_FRICT: begin
                    state_q      <= ST_IDLE;
                    pend_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (ovr_req && ((state_q == ST_MOVE) || (state_q == ST_WALL))) begin
                pend_valid_q <= 1'b1;
                pend_x_q     <= ovr_x;
                pend_y_q     <= ovr_y;
            end
        end
    end

    axis_integrator #(
        .INIT           (INIT_X),
        .MIN            (X_MIN),
        .MAX            (X_MAX),
        .FRICTION_SHIFT (FRICTION_SHIFT)
    ) u_axis_x (
        .clk        (clk),
        .reset      (reset),
        .move_i     (do_move),
        .wall_i     (do_wall),
        .frict_i    (do_frict),
        .load_i     (do_load),
        .load_vel_i (load_x),
        .pos_o      (ballTopLeftPosX),
        .vel_o      (ballVelX),
        .refl_o     (refl_x)
    );

    axis_integrator #(
        .INIT           (INIT_Y),
        .MIN            (Y_MIN),
        .MAX            (Y_MAX),
        .FRICTION_SHIFT (FRICTION_SHIFT)
    ) u_axis_y (
        .clk        (clk),
        .reset      (reset),
        .move_i     (do_move),
        .wall_i     (do_wall),
        .frict_i    (do_frict),
        .load_i     (do_load),
        .load_vel_i (load_y),
        .pos_o      (ballTopLeftPosY),
        .vel_o      (ballVelY),
        .refl_o     (refl_y)
    );

    assign moving  = (ballVelX != '0) || (ballVelY != '0);
    assign wallHit = wall_hit_q;

endmodule
